// File: rtl/data_unpack_gen.sv
// Word-to-symbol unpacker: splits IN_W-bit words into OUT_W-bit symbols, LSB first.
// Residue bits carry across words of a packet. Supports downstream backpressure, an
// end-of-packet partial-symbol flush (or discard) and flags a sop_in on an open packet.
module data_unpack_gen #(
    parameter int unsigned IN_W          = 32,
    parameter int unsigned OUT_W         = 7,
    parameter bit          FLUSH_PARTIAL = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_in,
    input  logic [IN_W-1:0]              data_in,
    input  logic                         sop_in,
    input  logic                         eop_in,
    output logic                         ready_out,
    output logic                         valid_out,
    output logic [OUT_W-1:0]             data_out,
    output logic                         sop_out,
    output logic                         eop_out,
    output logic [$clog2(OUT_W+1)-1:0]   valid_bits_out,
    input  logic                         ready_in,
    output logic                         sop_err
);

    localparam int unsigned BUF_W = IN_W + OUT_W - 1;
    localparam int unsigned CNT_W = $clog2(IN_W + OUT_W);
    localparam int unsigned VB_W  = $clog2(OUT_W + 1);

    localparam logic [CNT_W-1:0] OutWCnt = CNT_W'(OUT_W);
    localparam logic [CNT_W-1:0] InWCnt  = CNT_W'(IN_W);

    logic [BUF_W-1:0] resid_q, resid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sop_pend_q, sop_pend_d;
    logic             flush_pend_q, flush_pend_d;
    logic             pkt_open_q, pkt_open_d;
    logic             sop_err_q, sop_err_d;

    logic             full;
    logic [CNT_W-1:0] cnt_min;
    logic             eop_cond;
    logic             accept;
    logic             xfer;

    // Output decode from registered state only; no path from valid_in or ready_in.
    always_comb begin
        full     = (cnt_q >= OutWCnt);
        cnt_min  = full ? OutWCnt : cnt_q;
        if (FLUSH_PARTIAL) begin
            eop_cond = flush_pend_q && (cnt_q <= OutWCnt);
        end else begin
            eop_cond = flush_pend_q && (32'(cnt_q) < (2 * OUT_W));
        end
        ready_out      = !full && !flush_pend_q;
        valid_out      = full || (flush_pend_q && FLUSH_PARTIAL && (cnt_q != '0));
        data_out       = resid_q[OUT_W-1:0];
        sop_out        = valid_out && sop_pend_q;
        eop_out        = valid_out && eop_cond;
        valid_bits_out = valid_out ? VB_W'(cnt_min) : '0;
        sop_err        = sop_err_q;
        accept         = valid_in && ready_out;
        xfer           = valid_out && ready_in;
    end

    // Next-state: accept and transfer are mutually exclusive because ready_out
    // implies valid_out is low (cnt below OUT_W and no flush pending).
    always_comb begin
        resid_d      = resid_q;
        cnt_d        = cnt_q;
        sop_pend_d   = sop_pend_q;
        flush_pend_d = flush_pend_q;
        pkt_open_d   = pkt_open_q;
        sop_err_d    = 1'b0;
        if (accept) begin
            if (sop_in && pkt_open_q) begin
                // Restart: drop the old packet's residue.
                resid_d   = BUF_W'(data_in);
                cnt_d     = InWCnt;
                sop_err_d = 1'b1;
            end else begin
                // Bits above cnt are always zero, so OR-in places the word at cnt.
                resid_d = resid_q | (BUF_W'(data_in) << cnt_q);
                cnt_d   = cnt_q + InWCnt;
            end
            sop_pend_d   = sop_in;
            flush_pend_d = eop_in;
            pkt_open_d   = !eop_in;
        end else if (xfer) begin
            resid_d    = resid_q >> OUT_W;
            cnt_d      = cnt_q - cnt_min;
            sop_pend_d = 1'b0;
            if (eop_cond) begin
                flush_pend_d = 1'b0;
                if (!FLUSH_PARTIAL) begin
                    resid_d = '0;
                    cnt_d   = '0;
                end
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            resid_q      <= '0;
            cnt_q        <= '0;
            sop_pend_q   <= 1'b0;
            flush_pend_q <= 1'b0;
            pkt_open_q   <= 1'b0;
            sop_err_q    <= 1'b0;
        end else begin
            resid_q      <= resid_d;
            cnt_q        <= cnt_d;
            sop_pend_q   <= sop_pend_d;
            flush_pend_q <= flush_pend_d;
            pkt_open_q   <= pkt_open_d;
            sop_err_q    <= sop_err_d;
        end
    end

endmodule

// File: tb/tb_data_unpack_gen.sv
// Self-checking bench for data_unpack_gen: directed tables plus a bitstream reference
// model for longer packets, with a flush-discard instance for the FLUSH_PARTIAL=0 case.
module tb_data_unpack_gen;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
    } word_t;

    typedef struct packed {
        logic [6:0] data;
        logic [2:0] vb;
        logic       sop;
        logic       eop;
    } sym_t;

    logic        clk;
    logic        rst;
    logic        valid_in, sop_in, eop_in, ready_in;
    logic [31:0] data_in;
    logic        ready_out, valid_out, sop_out, eop_out, sop_err;
    logic [6:0]  data_out;
    logic [2:0]  valid_bits_out;

    logic        valid_in0, sop_in0, eop_in0, ready_in0;
    logic [31:0] data_in0;
    logic        ready_out0, valid_out0, sop_out0, eop_out0, sop_err0;
    logic [6:0]  data_out0;
    logic [2:0]  valid_bits_out0;

    word_t words[$];
    sym_t  cap[$];
    sym_t  expq[$];
    sym_t  t1[5];
    sym_t  t3[13];
    bit    tb_open;
    int    checks;
    int    passes;

    data_unpack_gen #(.IN_W(32), .OUT_W(7), .FLUSH_PARTIAL(1'b1)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in), .sop_in(sop_in),
        .eop_in(eop_in), .ready_out(ready_out), .valid_out(valid_out), .data_out(data_out),
        .sop_out(sop_out), .eop_out(eop_out), .valid_bits_out(valid_bits_out),
        .ready_in(ready_in), .sop_err(sop_err)
    );

    data_unpack_gen #(.IN_W(32), .OUT_W(7), .FLUSH_PARTIAL(1'b0)) dut0 (
        .clk(clk), .rst(rst), .valid_in(valid_in0), .data_in(data_in0), .sop_in(sop_in0),
        .eop_in(eop_in0), .ready_out(ready_out0), .valid_out(valid_out0),
        .data_out(data_out0), .sop_out(sop_out0), .eop_out(eop_out0),
        .valid_bits_out(valid_bits_out0), .ready_in(ready_in0), .sop_err(sop_err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: concatenate packet bits LSB-first and cut into 7-bit chunks.
    task automatic build_exp();
        bit   bits[$];
        bit   open;
        bit   sflag;
        sym_t s;
        int   n;
        open = 1'b0;
        expq.delete();
        foreach (words[i]) begin
            if (words[i].sop && open) bits.delete();
            sflag = words[i].sop;
            for (int b = 0; b < 32; b++) bits.push_back(words[i].data[b]);
            while (bits.size() >= 7) begin
                s = '0;
                for (int k = 0; k < 7; k++) s.data[k] = bits.pop_front();
                s.vb  = 3'd7;
                s.sop = sflag;
                sflag = 1'b0;
                s.eop = words[i].eop && (bits.size() == 0);
                expq.push_back(s);
            end
            if (words[i].eop && bits.size() > 0) begin
                s = '0;
                n = bits.size();
                for (int k = 0; k < n; k++) s.data[k] = bits.pop_front();
                s.vb  = 3'(n);
                s.sop = sflag;
                s.eop = 1'b1;
                expq.push_back(s);
            end
            open = !words[i].eop;
        end
    endtask

    task automatic compare_q(input string tag);
        int n;
        check({tag, "_count"}, 64'(cap.size()), 64'(expq.size()));
        n = (cap.size() < expq.size()) ? cap.size() : expq.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_sym%0d", tag, i), cap[i], expq[i]);
    endtask

    // Drive the main instance from words[]; samples on negedge, inputs change there too.
    task automatic run(input bit rnd, input int max_cyc);
        int   wi;
        bit   prev_stall;
        bit   exp_err;
        bit   done;
        sym_t prev;
        sym_t cur;
        wi = 0; prev_stall = 1'b0; exp_err = 1'b0; done = 1'b0; prev = '0;
        cap.delete();
        for (int c = 0; c < max_cyc && !done; c++) begin
            @(negedge clk);
            cur = {data_out, valid_bits_out, sop_out, eop_out};
            if (prev_stall) check("stall_hold", {valid_out, cur}, {1'b1, prev});
            check("no_accept_while_full", ready_out && valid_out, 1'b0);
            check("sop_err_pulse", sop_err, exp_err);
            exp_err = 1'b0;
            if (wi == words.size() && !valid_out) begin
                done = 1'b1;
                valid_in = 1'b0; sop_in = 1'b0; eop_in = 1'b0; ready_in = 1'b1;
            end else begin
                ready_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (wi < words.size()) begin
                    valid_in = 1'b1;
                    data_in  = words[wi].data;
                    sop_in   = words[wi].sop;
                    eop_in   = words[wi].eop;
                end else begin
                    valid_in = 1'b0; sop_in = 1'b0; eop_in = 1'b0;
                end
                if (valid_out && ready_in) cap.push_back(cur);
                prev_stall = valid_out && !ready_in;
                prev       = cur;
                if (valid_in && ready_out) begin
                    exp_err = sop_in && tb_open;
                    tb_open = !eop_in;
                    wi++;
                end
            end
        end
        check("run_done", done, 1'b1);
    endtask

    // Same driver for the discard instance, downstream always ready.
    task automatic run0(input int max_cyc);
        int wi;
        bit done;
        wi = 0; done = 1'b0;
        cap.delete();
        for (int c = 0; c < max_cyc && !done; c++) begin
            @(negedge clk);
            ready_in0 = 1'b1;
            if (wi == words.size() && !valid_out0) begin
                done = 1'b1;
                valid_in0 = 1'b0; sop_in0 = 1'b0; eop_in0 = 1'b0;
            end else begin
                if (wi < words.size()) begin
                    valid_in0 = 1'b1;
                    data_in0  = words[wi].data;
                    sop_in0   = words[wi].sop;
                    eop_in0   = words[wi].eop;
                end else begin
                    valid_in0 = 1'b0; sop_in0 = 1'b0; eop_in0 = 1'b0;
                end
                if (valid_out0) begin
                    cap.push_back({data_out0, valid_bits_out0, sop_out0, eop_out0});
                end
                if (valid_in0 && ready_out0) wi++;
            end
        end
        check("run0_done", done, 1'b1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, valid_out, 1'b0);
        check({tag, "_ready"}, ready_out, 1'b1);
        check({tag, "_sop"}, sop_out, 1'b0);
        check({tag, "_eop"}, eop_out, 1'b0);
        check({tag, "_err"}, sop_err, 1'b0);
        check({tag, "_data"}, data_out, 7'h0);
        check({tag, "_vb"}, valid_bits_out, 3'd0);
    endtask

    initial begin
        checks = 0; passes = 0; tb_open = 1'b0;
        t1[0] = '{7'h6F, 3'd7, 1'b1, 1'b0};
        t1[1] = '{7'h7D, 3'd7, 1'b0, 1'b0};
        t1[2] = '{7'h36, 3'd7, 1'b0, 1'b0};
        t1[3] = '{7'h75, 3'd7, 1'b0, 1'b0};
        t1[4] = '{7'h0D, 3'd4, 1'b0, 1'b1};
        // Discard mode: FFFFFFFF,80000000 then a single-word 00000055 packet.
        t3[0]  = '{7'h7F, 3'd7, 1'b1, 1'b0};
        t3[1]  = '{7'h7F, 3'd7, 1'b0, 1'b0};
        t3[2]  = '{7'h7F, 3'd7, 1'b0, 1'b0};
        t3[3]  = '{7'h7F, 3'd7, 1'b0, 1'b0};
        t3[4]  = '{7'h0F, 3'd7, 1'b0, 1'b0};
        t3[5]  = '{7'h00, 3'd7, 1'b0, 1'b0};
        t3[6]  = '{7'h00, 3'd7, 1'b0, 1'b0};
        t3[7]  = '{7'h00, 3'd7, 1'b0, 1'b0};
        t3[8]  = '{7'h00, 3'd7, 1'b0, 1'b1};
        t3[9]  = '{7'h55, 3'd7, 1'b1, 1'b0};
        t3[10] = '{7'h00, 3'd7, 1'b0, 1'b0};
        t3[11] = '{7'h00, 3'd7, 1'b0, 1'b0};
        t3[12] = '{7'h00, 3'd7, 1'b0, 1'b1};

        rst = 1'b1;
        valid_in = 1'b0; data_in = '0; sop_in = 1'b0; eop_in = 1'b0; ready_in = 1'b1;
        valid_in0 = 1'b0; data_in0 = '0; sop_in0 = 1'b0; eop_in0 = 1'b0; ready_in0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_idle("reset");
        rst = 1'b0;

        // 1: single-word packet with partial flush.
        words.delete();
        words.push_back('{32'hDEADBEEF, 1'b1, 1'b1});
        run(1'b0, 200);
        check("t1_ready_after_eop", ready_out, 1'b1);
        expq.delete();
        foreach (t1[i]) expq.push_back(t1[i]);
        compare_q("t1");

        // 2: seven random words, no partial symbol.
        words.delete();
        for (int i = 0; i < 7; i++) words.push_back('{$urandom(), i == 0, i == 6});
        run(1'b0, 500);
        build_exp();
        check("t2_model_len", 64'(expq.size()), 64'd32);
        compare_q("t2");

        // 3: two-word packet, flush keeps one bit (bit 63 of the stream).
        words.delete();
        words.push_back('{32'hFFFFFFFF, 1'b1, 1'b0});
        words.push_back('{32'h80000000, 1'b0, 1'b1});
        run(1'b0, 500);
        build_exp();
        compare_q("t3");
        if (cap.size() == 10) begin
            check("t3_last_vb", cap[9].vb, 3'd1);
            check("t3_last_data", cap[9].data, 7'h01);
        end else begin
            check("t3_count10", 64'(cap.size()), 64'd10);
        end

        // 3b: discard mode, then a fresh packet proves residue was cleared.
        words.push_back('{32'h00000055, 1'b1, 1'b1});
        run0(500);
        expq.delete();
        foreach (t3[i]) expq.push_back(t3[i]);
        compare_q("t3_discard");
        check("t3_discard_ready", ready_out0, 1'b1);

        // 4: 100-word packet with random backpressure.
        words.delete();
        for (int i = 0; i < 100; i++) words.push_back('{$urandom(), i == 0, i == 99});
        run(1'b1, 5000);
        build_exp();
        compare_q("t4");

        // 5: sop on the 3rd word of an open packet, then a sop-less packet.
        words.delete();
        words.push_back('{32'h13579BDF, 1'b1, 1'b0});
        words.push_back('{32'h2468ACE0, 1'b0, 1'b0});
        words.push_back('{32'hA5A5A5A5, 1'b1, 1'b0});
        words.push_back('{32'h0F0F0F0F, 1'b0, 1'b1});
        words.push_back('{32'hCAFEF00D, 1'b0, 1'b1});
        run(1'b0, 500);
        build_exp();
        compare_q("t5");

        // 6: reset while a symbol is pending.
        @(negedge clk);
        valid_in = 1'b1; data_in = 32'h12345678; sop_in = 1'b1; eop_in = 1'b0; ready_in = 1'b0;
        @(negedge clk);
        valid_in = 1'b0; sop_in = 1'b0;
        check("t6_pre_valid", valid_out, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tb_open = 1'b0;
        check_idle("t6_reset");
        words.delete();
        words.push_back('{32'h0BADC0DE, 1'b1, 1'b0});
        words.push_back('{32'h600DF00D, 1'b0, 1'b1});
        run(1'b0, 500);
        build_exp();
        compare_q("t6");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
